// File: rtl/vga_demo.sv
// vga_demo: 640x480 @ 60 Hz VGA test-pattern generator (25 MHz pixel clock).
//   Free-running horizontal and vertical counters drive a combinational
//   timing/pattern decode. The decode is registered once so that all three
//   outputs come straight from flops and stay mutually aligned.
// Ports:
//   clk_25    in   pixel clock, all logic on the rising edge
//   rst       in   asynchronous, active-high reset
//   pixel     out  [2:0] registered RGB {R,G,B}; zero during blanking
//   hsync_out out  registered horizontal sync, active low
//   vsync_out out  registered vertical sync, active low
module vga_demo #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int BAR_WIDTH = 80
) (
  input  logic       clk_25,
  input  logic       rst,
  output logic [2:0] pixel,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Colour-bar boundaries; bar index is found by comparison, not division.
  localparam logic [9:0] BAR1 = 10'(BAR_WIDTH * 1);
  localparam logic [9:0] BAR2 = 10'(BAR_WIDTH * 2);
  localparam logic [9:0] BAR3 = 10'(BAR_WIDTH * 3);
  localparam logic [9:0] BAR4 = 10'(BAR_WIDTH * 4);
  localparam logic [9:0] BAR5 = 10'(BAR_WIDTH * 5);
  localparam logic [9:0] BAR6 = 10'(BAR_WIDTH * 6);
  localparam logic [9:0] BAR7 = 10'(BAR_WIDTH * 7);

  logic [9:0] h_count_r;
  logic [9:0] v_count_r;

  logic       visible_s;
  logic       border_s;
  logic       hsync_n_s;
  logic       vsync_n_s;
  logic [2:0] bar_s;
  logic [2:0] pattern_s;

  // Raster counters: h wraps every line, v advances only on the h wrap.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      h_count_r <= 10'd0;
      v_count_r <= 10'd0;
    end else if (h_count_r == H_MAX) begin
      h_count_r <= 10'd0;
      if (v_count_r == V_MAX) begin
        v_count_r <= 10'd0;
      end else begin
        v_count_r <= v_count_r + 10'd1;
      end
    end else begin
      h_count_r <= h_count_r + 10'd1;
    end
  end

  // Timing decode of the current counter values.
  always_comb begin
    visible_s = 1'b0;
    hsync_n_s = 1'b1;
    vsync_n_s = 1'b1;
    if ((h_count_r < H_VIS) && (v_count_r < V_VIS)) begin
      visible_s = 1'b1;
    end else begin
      visible_s = 1'b0;
    end
    if ((h_count_r >= HS_START) && (h_count_r <= HS_END)) begin
      hsync_n_s = 1'b0;
    end else begin
      hsync_n_s = 1'b1;
    end
    if ((v_count_r >= VS_START) && (v_count_r <= VS_END)) begin
      vsync_n_s = 1'b0;
    end else begin
      vsync_n_s = 1'b1;
    end
  end

  // Bar index via a descending comparator chain (first match wins).
  always_comb begin
    bar_s = 3'd0;
    if (h_count_r >= BAR7) begin
      bar_s = 3'd7;
    end else if (h_count_r >= BAR6) begin
      bar_s = 3'd6;
    end else if (h_count_r >= BAR5) begin
      bar_s = 3'd5;
    end else if (h_count_r >= BAR4) begin
      bar_s = 3'd4;
    end else if (h_count_r >= BAR3) begin
      bar_s = 3'd3;
    end else if (h_count_r >= BAR2) begin
      bar_s = 3'd2;
    end else if (h_count_r >= BAR1) begin
      bar_s = 3'd1;
    end else begin
      bar_s = 3'd0;
    end
  end

  // Pattern select: blanking is forced to black, the frame edge is white.
  always_comb begin
    border_s  = 1'b0;
    pattern_s = 3'b000;
    if ((h_count_r == 10'd0) || (h_count_r == H_LAST) ||
        (v_count_r == 10'd0) || (v_count_r == V_LAST)) begin
      border_s = 1'b1;
    end else begin
      border_s = 1'b0;
    end
    if (!visible_s) begin
      pattern_s = 3'b000;
    end else if (border_s) begin
      pattern_s = 3'b111;
    end else begin
      pattern_s = bar_s;
    end
  end

  // Output register: every output lags its counter value by one clock.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      pixel     <= 3'b000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      pixel     <= pattern_s;
      hsync_out <= hsync_n_s;
      vsync_out <= vsync_n_s;
    end
  end

endmodule

// File: tb/tb_vga_demo.sv
`timescale 1ns/1ps
module tb_vga_demo;

  // Reduced vertical geometry for the second instance so whole frames fit in a short run.
  localparam int SV_VIS   = 24;
  localparam int SV_FRONT = 3;
  localparam int SV_SYNC  = 2;
  localparam int SV_BACK  = 3;
  localparam int SV_TOT   = SV_VIS + SV_FRONT + SV_SYNC + SV_BACK;   // 32 lines
  localparam int S_FRAME  = 800 * SV_TOT;                            // 25600 clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pixel_d, pixel_s;
  logic       hs_d, vs_d, hs_s, vs_s;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;      // rising edges since reset was last released
  bit fc_en    = 1'b0;
  logic [4:0] f1 [1600];

  always #20 clk = ~clk;

  vga_demo dut_d (
    .clk_25(clk), .rst(rst), .pixel(pixel_d), .hsync_out(hs_d), .vsync_out(vs_d)
  );

  vga_demo #(.V_VISIBLE(SV_VIS), .V_FRONT(SV_FRONT), .V_SYNC(SV_SYNC), .V_BACK(SV_BACK)) dut_s (
    .clk_25(clk), .rst(rst), .pixel(pixel_s), .hsync_out(hs_s), .vsync_out(vs_s)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edges = 0;
    else     edges = edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edges, $time);
    end
  endtask

  // Reference: after k edges the outputs show raster position k-1, computed arithmetically.
  function automatic logic [4:0] exp_out(input int k, input int vtot, input int vvis,
                                         input int vs_start, input int vs_len);
    int n, h, v;
    logic [2:0] pix;
    logic hs, vs;
    if (k == 0) return 5'b000_1_1;
    n = (k - 1) % (800 * vtot);
    h = n % 800;
    v = n / 800;
    if (h >= 640 || v >= vvis)                      pix = 3'b000;
    else if (h == 0 || h == 639 || v == 0 || v == vvis - 1) pix = 3'b111;
    else                                            pix = 3'(h / 80);
    hs = !(h >= 656 && h < 656 + 96);
    vs = !(v >= vs_start && v < vs_start + vs_len);
    return {pix, hs, vs};
  endfunction

  // Continuous comparison of both instances against the reference.
  always @(negedge clk) begin
    check("stream_default", {pixel_d, hs_d, vs_d}, exp_out(edges, 525, 480, 490, 2));
    check("stream_small", {pixel_s, hs_s, vs_s},
          exp_out(edges, SV_TOT, SV_VIS, SV_VIS + SV_FRONT, SV_SYNC));
  end

  // Pulse-width and period measurement of hsync (default) and vsync (small).
  int  hs_fall, vs_fall;
  bit  hs_valid = 1'b0, vs_valid = 1'b0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      hs_valid = 1'b0; vs_valid = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      if (hs_prev && !hs_d) begin
        if (hs_valid) check("hsync_period", edges - hs_fall, 800);
        hs_fall = edges; hs_valid = 1'b1;
      end else if (!hs_prev && hs_d && hs_valid) begin
        check("hsync_width", edges - hs_fall, 96);
      end
      if (vs_prev && !vs_s) begin
        if (vs_valid) check("vsync_period", edges - vs_fall, S_FRAME);
        vs_fall = edges; vs_valid = 1'b1;
      end else if (!vs_prev && vs_s && vs_valid) begin
        check("vsync_width", edges - vs_fall, 1600);
      end
      hs_prev = hs_d; vs_prev = vs_s;
    end
  end

  // First two lines of frame 2 must repeat frame 1 bit-exactly.
  always @(negedge clk) begin
    if (!rst && fc_en) begin
      if (edges >= 1 && edges <= 1600) f1[edges - 1] = {pixel_s, hs_s, vs_s};
      if (edges > S_FRAME && edges <= S_FRAME + 1600)
        check("frame_wrap", {pixel_s, hs_s, vs_s}, f1[edges - S_FRAME - 1]);
    end
  end

  typedef struct {
    int         sel;      // 0: default geometry, 1: reduced vertical geometry
    int         edge_n;
    logic [2:0] pix;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl[$];

  task automatic wait_edge(input int target);
    int guard = 0;
    while (edges < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_edge", edges, target);
  endtask

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // sel, edge, pixel, hsync, vsync
    tbl.push_back('{0,     1, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,     2, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,   640, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,   641, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   656, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   657, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{0,   752, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{0,   753, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   800, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   801, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,   802, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   880, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,   881, 3'b001, 1'b1, 1'b1});
    tbl.push_back('{0,   960, 3'b001, 1'b1, 1'b1});
    tbl.push_back('{0,   961, 3'b010, 1'b1, 1'b1});
    tbl.push_back('{0,  1361, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,  1439, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,  1440, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{0,  1441, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{0,  1901, 3'b011, 1'b1, 1'b1});
    tbl.push_back('{1, 17901, 3'b011, 1'b1, 1'b1});
    tbl.push_back('{1, 18701, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{1, 19211, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{1, 21600, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{1, 21601, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{1, 23200, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{1, 23201, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{1, 25600, 3'b000, 1'b1, 1'b1});
    tbl.push_back('{1, 25601, 3'b111, 1'b1, 1'b1});
    tbl.push_back('{1, 25602, 3'b111, 1'b1, 1'b1});

    // Reset held for 5 clocks.
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", {pixel_d, hs_d, vs_d}, 5'b000_1_1);
    end
    fc_en = 1'b1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      wait_edge(tbl[i].edge_n);
      if (tbl[i].sel == 0)
        check($sformatf("vec%0d_default", i), {pixel_d, hs_d, vs_d}, {tbl[i].pix, tbl[i].hs, tbl[i].vs});
      else
        check($sformatf("vec%0d_small", i), {pixel_s, hs_s, vs_s}, {tbl[i].pix, tbl[i].hs, tbl[i].vs});
    end
    wait_edge(S_FRAME + 1700);
    fc_en = 1'b0;

    // Mid-frame reset: small instance at line 12, h=300 of frame 2.
    wait_edge(S_FRAME + 12 * 800 + 301);
    check("pre_reset_bar", pixel_s, 3'b011);
    #2 rst = 1'b1;
    #1;
    check("async_reset_default", {pixel_d, hs_d, vs_d}, 5'b000_1_1);
    check("async_reset_small", {pixel_s, hs_s, vs_s}, 5'b000_1_1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    wait_edge(1);
    check("post_reset_corner_d", pixel_d, 3'b111);
    check("post_reset_corner_s", pixel_s, 3'b111);
    wait_edge(802);
    check("post_reset_line1_d", pixel_d, 3'b000);
    wait_edge(1700);

    // Randomly timed resets; the reference stream keeps checking throughout.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(900, 4000)) @(negedge clk);
      #($urandom_range(1, 15)) rst = 1'b1;
      #1;
      check("rand_async_reset", {pixel_d, hs_d, vs_d, pixel_s, hs_s, vs_s}, 10'b000_1_1_000_1_1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (900) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_demo.md
Name: vga_demo

Overview:
- Self-contained VGA test-pattern generator for 640x480 at 60 Hz, driven from a 25 MHz pixel clock.
- Contains the horizontal/vertical sync timing generator plus a pattern generator producing a 3-bit RGB pixel stream (R=bit2, G=bit1, B=bit0).
- Sits at the top of a demo design, feeding the board's VGA connector directly.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- BAR_WIDTH, 80, width in pixels of each colour bar

Ports:
- clk_25  input  1  25 MHz pixel clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- pixel  output  3  registered RGB pixel {R,G,B}
- hsync_out  output  1  registered horizontal sync, active low
- vsync_out  output  1  registered vertical sync, active low

Behaviour:
- Single clock domain (clk_25). Reset is asynchronous and active-high. While rst=1: h_count=0, v_count=0, pixel=3'b000, hsync_out=1, vsync_out=1.
- Horizontal counter h_count: 10 bits, range 0..H_TOTAL-1.
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK = 800.
  - Increments every clock; wraps 799->0.
- Vertical counter v_count: 10 bits, range 0..V_TOTAL-1.
  - V_TOTAL = 525.
  - Increments only on the clock where h_count wraps 799->0; wraps 524->0 at that same edge.
- Combinational timing decode from current counters:
  - visible = (h_count < 640) && (v_count < 480).
  - hsync_n = 0 when 656 <= h_count <= 751, else 1.
  - vsync_n = 0 when 490 <= v_count <= 491, else 1.
- Pattern (when visible):
  - Border override: if h_count==0, h_count==639, v_count==0 or v_count==479, the pattern is 3'b111.
  - Otherwise bar = h_count / BAR_WIDTH (0..7), implemented with a comparator chain, no divider; the pattern is bar[2:0].
  - Bar ranges: 0..79 -> 000, 80..159 -> 001, ..., 560..639 -> 111.
- When not visible, the pattern is 3'b000. Blanking must be exactly zero for all porches and sync intervals.
- Output register stage: pixel, hsync_out and vsync_out are registered from the decode of the current counter values. Each output therefore lags its counter value by exactly one clock, and all three outputs stay mutually aligned.
- Frame period is 800*525 = 420000 clocks. The hsync low pulse lasts exactly 96 clocks per line. The vsync low pulse lasts exactly 2*800 = 1600 clocks per frame.
- No glitches: all outputs come straight from flops.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). After deassertion, the first rising edge registers the decode of h_count=0, v_count=0, so pixel becomes 3'b111 (border).

Test Plan:
- Reset: hold rst=1 for 5 clocks -> pixel=000, hsync_out=1, vsync_out=1 throughout. Release -> after 1st edge pixel=111 (corner border).
- Line 1 content: from reset release, sample pixel on edges 1..640 (pixel at edge k reflects h_count=k-1):
  - v_count=0 is a border line, so all 640 pixels = 111.
  - Line v=1, edges 801..1440: expect 111 at h=0; 000 for h=1..79; 001 for 80..159; and so on up to 111 for 560..638; 111 border at 639.
- Horizontal timing: measure hsync_out -> falls 657 clocks after reset release (h=656 registered), stays low 96 clocks, period 800 clocks; pixel=000 for h=640..799.
- Vertical timing: vsync_out falls when v_count=490, h_count=0 registers, i.e. edge 490*800+1 after release; low for 1600 clocks; next fall 420000 clocks later. No pixel≠000 on lines 480..524.
- Frame wrap: after 420000 clocks the pattern repeats identically. Compare the first line of frame 2 with frame 1 and expect a bit-exact match.
- Mid-frame reset: assert rst asynchronously at line 200, h=300 (between edges) -> outputs go to reset values before the next edge. Release -> timing restarts from h=0, v=0 exactly as in the Reset scenario.
